// File: rtl/a_igual_b_pkg.sv
// Shared definitions for the a_igual_b comparator and its upstream sequencer.
package a_igual_b_pkg;

    localparam int unsigned A_IGUAL_B_INPUTSIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/a_igual_b_ctrl.sv
// Sequencer for the a_igual_b equality comparator: registers a compare request,
// holds the comparator enable until done (or timeout), and returns a branch decision.
module a_igual_b_ctrl
    import a_igual_b_pkg::*;
#(
    parameter int unsigned INPUTSIZE = A_IGUAL_B_INPUTSIZE,
    parameter int unsigned ADDRSIZE  = 8,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNTSIZE   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [INPUTSIZE-1:0] req_a,
    input  logic [INPUTSIZE-1:0] req_b,
    input  logic                 req_bne,
    input  logic [ADDRSIZE-1:0]  req_target,
    output logic                 cmp_enable,
    output logic [INPUTSIZE-1:0] cmp_a,
    output logic [INPUTSIZE-1:0] cmp_b,
    input  logic                 cmp_ab_out,
    input  logic                 cmp_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_eq,
    output logic                 rsp_take,
    output logic [ADDRSIZE-1:0]  rsp_target,
    output logic                 rsp_err,
    output logic [CNTSIZE-1:0]   cnt_total,
    output logic [CNTSIZE-1:0]   cnt_equal
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [CNTSIZE-1:0] CMAX = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_nxt;
    logic                r_bne;
    logic [ADDRSIZE-1:0] r_target;
    logic                w_accept;
    logic                w_finish;
    logic                w_rsp_hs;
    logic                w_take;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_rsp_hs    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                // done has priority over a timeout landing on the same cycle
                if (cmp_done || (r_timer == TLAST)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_take = cmp_ab_out ^ r_bne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bne      <= 1'b0;
            r_target   <= '0;
            req_ready  <= 1'b1;
            cmp_enable <= 1'b0;
            cmp_a      <= '0;
            cmp_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_take   <= 1'b0;
            rsp_target <= '0;
            rsp_err    <= 1'b0;
            cnt_total  <= '0;
            cnt_equal  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            req_ready  <= (w_state_nxt == IDLE);
            cmp_enable <= (w_state_nxt == EVAL);
            rsp_valid  <= (w_state_nxt == RESP);
            if (w_accept) begin
                cmp_a    <= req_a;
                cmp_b    <= req_b;
                r_bne    <= req_bne;
                r_target <= req_target;
            end
            if (w_finish) begin
                if (cmp_done) begin
                    rsp_eq     <= cmp_ab_out;
                    rsp_take   <= w_take;
                    rsp_target <= w_take ? r_target : '0;
                    rsp_err    <= 1'b0;
                end else begin
                    rsp_eq     <= 1'b0;
                    rsp_take   <= 1'b0;
                    rsp_target <= '0;
                    rsp_err    <= 1'b1;
                end
            end
            if (w_rsp_hs) begin
                if (cnt_total != CMAX) cnt_total <= cnt_total + 1'b1;
                if (rsp_eq && (cnt_equal != CMAX)) cnt_equal <= cnt_equal + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a_igual_b_ctrl.sv
// Randomized self-checking bench for a_igual_b_ctrl with a delay-programmable comparator stub;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_a_igual_b_ctrl;

    localparam int unsigned INPUTSIZE = 4;
    localparam int unsigned ADDRSIZE  = 8;
    localparam int unsigned TIMEOUT   = 15;
    localparam int unsigned CNTSIZE   = 8;
    localparam int unsigned CNTSIZE_S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                 req_valid = 1'b0;
    logic [INPUTSIZE-1:0] req_a = '0;
    logic [INPUTSIZE-1:0] req_b = '0;
    logic                 req_bne = 1'b0;
    logic [ADDRSIZE-1:0]  req_target = '0;
    logic                 rsp_ready = 1'b0;

    logic                 req_ready0, cmp_enable0, cmp_ab0, cmp_done0;
    logic                 rsp_valid0, rsp_eq0, rsp_take0, rsp_err0;
    logic [INPUTSIZE-1:0] cmp_a0, cmp_b0;
    logic [ADDRSIZE-1:0]  rsp_target0;
    logic [CNTSIZE-1:0]   cnt_total0, cnt_equal0;

    logic                 req_ready1, cmp_enable1, cmp_ab1, cmp_done1;
    logic                 rsp_valid1, rsp_eq1, rsp_take1, rsp_err1;
    logic [INPUTSIZE-1:0] cmp_a1, cmp_b1;
    logic [ADDRSIZE-1:0]  rsp_target1;
    logic [CNTSIZE_S-1:0] cnt_total1, cnt_equal1;

    // Comparator stub: done rises done_dly cycles into the enable window; noise outside it.
    int unsigned done_dly = 0;
    int unsigned en_cnt0 = 0;
    int unsigned en_cnt1 = 0;
    logic [1:0]  noise = '0;

    always @(negedge clk) noise <= 2'($urandom);
    always @(posedge clk) en_cnt0 <= cmp_enable0 ? en_cnt0 + 1 : 0;
    always @(posedge clk) en_cnt1 <= cmp_enable1 ? en_cnt1 + 1 : 0;

    assign cmp_done0 = cmp_enable0 ? (en_cnt0 >= done_dly) : noise[0];
    assign cmp_ab0   = cmp_enable0 ? (cmp_a0 == cmp_b0)    : noise[1];
    assign cmp_done1 = cmp_enable1 ? (en_cnt1 >= done_dly) : noise[0];
    assign cmp_ab1   = cmp_enable1 ? (cmp_a1 == cmp_b1)    : noise[1];

    a_igual_b_ctrl #(
        .INPUTSIZE(INPUTSIZE), .ADDRSIZE(ADDRSIZE), .TIMEOUT(TIMEOUT), .CNTSIZE(CNTSIZE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b), .req_bne(req_bne), .req_target(req_target),
        .cmp_enable(cmp_enable0), .cmp_a(cmp_a0), .cmp_b(cmp_b0),
        .cmp_ab_out(cmp_ab0), .cmp_done(cmp_done0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_eq(rsp_eq0), .rsp_take(rsp_take0), .rsp_target(rsp_target0), .rsp_err(rsp_err0),
        .cnt_total(cnt_total0), .cnt_equal(cnt_equal0)
    );

    a_igual_b_ctrl #(
        .INPUTSIZE(INPUTSIZE), .ADDRSIZE(ADDRSIZE), .TIMEOUT(TIMEOUT), .CNTSIZE(CNTSIZE_S)
    ) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .req_bne(req_bne), .req_target(req_target),
        .cmp_enable(cmp_enable1), .cmp_a(cmp_a1), .cmp_b(cmp_b1),
        .cmp_ab_out(cmp_ab1), .cmp_done(cmp_done1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_eq(rsp_eq1), .rsp_take(rsp_take1), .rsp_target(rsp_target1), .rsp_err(rsp_err1),
        .cnt_total(cnt_total1), .cnt_equal(cnt_equal1)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned m_tot = 0;
    int unsigned m_eq  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned w);
        int unsigned mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_cnt_total"},   cnt_total0, sat(m_tot, CNTSIZE));
        check({tag, "_cnt_equal"},   cnt_equal0, sat(m_eq, CNTSIZE));
        check({tag, "_cnt_total_s"}, cnt_total1, sat(m_tot, CNTSIZE_S));
        check({tag, "_cnt_equal_s"}, cnt_equal1, sat(m_eq, CNTSIZE_S));
    endtask

    task automatic check_rsp(input string tag, input logic eq, input logic take,
                             input logic [ADDRSIZE-1:0] tgt, input logic err);
        check({tag, "_valid"},  rsp_valid0,  1);
        check({tag, "_eq"},     rsp_eq0,     eq);
        check({tag, "_take"},   rsp_take0,   take);
        check({tag, "_target"}, rsp_target0, tgt);
        check({tag, "_err"},    rsp_err0,    err);
        check({tag, "_valid_s"}, rsp_valid1, 1);
        check({tag, "_take_s"},  rsp_take1,  take);
    endtask

    // One full transaction: dly = cycle of done within the enable window, bp = cycles of rsp backpressure.
    task automatic run_txn(input logic [INPUTSIZE-1:0] a, input logic [INPUTSIZE-1:0] b,
                           input logic bne, input logic [ADDRSIZE-1:0] tgt,
                           input int unsigned dly, input int unsigned bp);
        logic                exp_eq, exp_take, exp_err;
        logic [ADDRSIZE-1:0] exp_tgt;
        int unsigned         exp_lat, lat;
        bit                  seen;
        if (dly < TIMEOUT) begin
            exp_err = 1'b0;
            exp_eq  = (a == b);
            exp_lat = 2 + dly;
        end else begin
            exp_err = 1'b1;
            exp_eq  = 1'b0;
            exp_lat = TIMEOUT + 1;
        end
        exp_take = exp_err ? 1'b0 : (exp_eq ^ bne);
        exp_tgt  = exp_take ? tgt : '0;
        done_dly = dly;

        @(negedge clk);
        check("idle_req_ready", req_ready0, 1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_bne    = bne;
        req_target = tgt;
        rsp_ready  = (bp == 0);
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid  = 1'b0;
                req_a      = 4'($urandom);
                req_b      = 4'($urandom);
                req_target = 8'($urandom);
                check("eval_cmp_a", cmp_a0, a);
                check("eval_cmp_b", cmp_b0, b);
            end
            if (rsp_valid0) begin
                seen = 1;
                lat  = k;
            end else begin
                check("eval_enable", cmp_enable0, 1);
                check("eval_req_ready", req_ready0, 0);
            end
        end
        check("rsp_valid_seen", rsp_valid0, 1);
        if (!seen) return;
        check("latency", lat, exp_lat);
        check("resp_enable_low", cmp_enable0, 0);
        check_rsp("rsp", exp_eq, exp_take, exp_tgt, exp_err);
        check_cnt("pre");

        for (int i = 0; i < int'(bp); i++) begin
            req_valid = 1'b1;
            req_a     = 4'($urandom);
            req_b     = 4'($urandom);
            @(negedge clk);
            check_rsp("hold", exp_eq, exp_take, exp_tgt, exp_err);
            check("hold_req_ready", req_ready0, 0);
            check_cnt("hold");
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_tot++;
        if (exp_eq) m_eq++;
        check("post_rsp_valid", rsp_valid0, 0);
        check("post_req_ready", req_ready0, 1);
        check("post_cmp_a_kept", cmp_a0, a);
        check("post_cmp_b_kept", cmp_b0, b);
        check_cnt("post");
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready0, 1);
        check("rst_cmp_enable", cmp_enable0, 0);
        check("rst_rsp_valid", rsp_valid0, 0);
        check("rst_rsp_take", rsp_take0, 0);
        check("rst_rsp_err", rsp_err0, 0);
        check("rst_cmp_a", cmp_a0, 0);
        check_cnt("rst");
        rst_n = 1'b1;

        run_txn(4'hA, 4'hA, 1'b0, 8'h3C, 0, 0);
        run_txn(4'h5, 4'h6, 1'b1, 8'h10, 0, 0);
        run_txn(4'h7, 4'h7, 1'b1, 8'h55, 0, 5);
        run_txn(4'h3, 4'h3, 1'b0, 8'hF0, 100, 0);
        run_txn(4'h9, 4'h9, 1'b0, 8'h21, TIMEOUT - 1, 1);
        run_txn(4'h9, 4'h9, 1'b0, 8'h22, TIMEOUT, 0);

        // Reset while the comparator enable is held
        done_dly = 100;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 4'h3;
        req_b     = 4'h3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_eval_enable", cmp_enable0, 1);
        done_dly = 0;
        rst_n = 1'b0;
        #1;
        m_tot = 0;
        m_eq  = 0;
        check("arst_cmp_enable", cmp_enable0, 0);
        check("arst_req_ready", req_ready0, 1);
        check("arst_rsp_valid", rsp_valid0, 0);
        check_cnt("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("arst_no_rsp", rsp_valid0, 0);
        end

        for (int i = 0; i < 5; i++) run_txn(4'(i), 4'(i), 1'b0, 8'(i + 1), 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [INPUTSIZE-1:0] a, b;
            int unsigned r, dly;
            a = 4'($urandom);
            b = $urandom_range(0, 1) ? a : 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 5)      dly = 0;
            else if (r < 8) dly = $urandom_range(1, TIMEOUT - 1);
            else            dly = $urandom_range(TIMEOUT, TIMEOUT + 10);
            run_txn(a, b, 1'($urandom), 8'($urandom), dly, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
